qduc_interp: RTL and testbench



---
 rtl/qduc_interp.sv | 173 +++++++++++++++++
 tb/tb_qduc_interp.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/qduc_interp.sv
// qduc_interp: I/Q CIC interpolating up-converter front end.
// Two matched N_STAGES CIC interpolators (I and Q) share one phase counter.
// Baseband pairs are accepted once every 2^R_LOG2 clocks through in_valid/in_ready.
// One gain-normalised output pair is produced every clk.
//
// Ports:
//   clk        system / DAC-rate clock
//   reset      synchronous, active-high reset
//   in_i/in_q  ISZ-bit two's complement baseband sample pair
//   in_valid   input pair valid
//   in_ready   single-cycle strobe every R clocks; a transfer happens when in_valid & in_ready
//   out_i/out_q  OSZ-bit two's complement output, updated every clk
//   out_valid  output stream valid; stays high once set until reset
//   underflow  sticky; set when a strobe passed with no valid input
//
// Optional feature macro: QDUC_ROUND_SAT_EN
//   When defined, the output uses round-half-up and saturation, and one extra
//   output pipeline register is added.
module qduc_interp #(
  parameter int unsigned ISZ      = 16,
  parameter int unsigned OSZ      = 14,
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned R_LOG2   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [ISZ-1:0] in_i,
  input  logic [ISZ-1:0] in_q,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [OSZ-1:0] out_i,
  output logic [OSZ-1:0] out_q,
  output logic           out_valid,
  output logic           underflow
);

  localparam int unsigned W = ISZ + N_STAGES * R_LOG2;
  localparam int unsigned S = (N_STAGES - 1) * R_LOG2 + (ISZ - OSZ);
`ifdef QDUC_ROUND_SAT_EN
  localparam int unsigned LAT = N_STAGES + 3;
  localparam int unsigned SM1 = (S > 0) ? S - 1 : 0;
  localparam logic signed [W:0] RND    = (S > 0) ? ((W+1)'(1) << SM1) : '0;
  localparam logic signed [W:0] SAT_HI = (W+1)'((2 ** (OSZ - 1)) - 1);
  localparam logic signed [W:0] SAT_LO = ~SAT_HI;
`else
  localparam int unsigned LAT = N_STAGES + 2;
`endif
  localparam logic [R_LOG2-1:0] PH_LAST = '1;

  // Channel index 0 is I, 1 is Q; both paths are identical.
  logic [R_LOG2-1:0]    r_phase;
  logic                 w_strobe;
  logic signed [W-1:0]  w_in    [2];
  logic signed [W-1:0]  r_samp  [2];
  logic signed [W-1:0]  r_dly   [2][N_STAGES];
  logic signed [W-1:0]  w_cmb   [2][N_STAGES+1];
  logic signed [W-1:0]  r_stuff [2];
  logic signed [W-1:0]  r_int   [2][N_STAGES];
  logic [OSZ-1:0]       w_norm  [2];
  logic [OSZ-1:0]       r_out   [2];
  logic [LAT-1:0]       r_vsr;
  logic                 r_out_valid;
  logic                 r_underflow;
`ifdef QDUC_ROUND_SAT_EN
  logic signed [W:0]    w_rnd   [2];
  logic signed [W:0]    w_shr   [2];
  logic [OSZ-1:0]       r_pipe  [2];
`endif

  // Strobe on the last phase; forced low while reset is asserted.
  always_comb begin
    w_strobe = (r_phase == PH_LAST) && !reset;
    in_ready = w_strobe;
  end

  // Sign-extend the incoming pair to the internal width.
  always_comb begin
    w_in[0] = {{(W-ISZ){in_i[ISZ-1]}}, in_i};
    w_in[1] = {{(W-ISZ){in_q[ISZ-1]}}, in_q};
  end

  // Comb chain (M = 1): stage k output = input - delayed input.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_cmb[c][0] = r_samp[c];
      for (int k = 0; k < N_STAGES; k++) begin
        w_cmb[c][k+1] = w_cmb[c][k] - r_dly[c][k];
      end
    end
  end

  // Gain normalisation of the last integrator.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
`ifdef QDUC_ROUND_SAT_EN
      w_rnd[c] = {r_int[c][N_STAGES-1][W-1], r_int[c][N_STAGES-1]} + RND;
      w_shr[c] = w_rnd[c] >>> S;
      if (w_shr[c] > SAT_HI) begin
        w_norm[c] = SAT_HI[OSZ-1:0];
      end else if (w_shr[c] < SAT_LO) begin
        w_norm[c] = SAT_LO[OSZ-1:0];
      end else begin
        w_norm[c] = w_shr[c][OSZ-1:0];
      end
`else
      w_norm[c] = OSZ'(r_int[c][N_STAGES-1] >>> S);
`endif
    end
  end

  // Datapath, phase counter and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase     <= '0;
      r_vsr       <= '0;
      r_out_valid <= 1'b0;
      r_underflow <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        r_samp[c]  <= '0;
        r_stuff[c] <= '0;
        r_out[c]   <= '0;
`ifdef QDUC_ROUND_SAT_EN
        r_pipe[c]  <= '0;
`endif
        for (int k = 0; k < N_STAGES; k++) begin
          r_dly[c][k] <= '0;
          r_int[c][k] <= '0;
        end
      end
    end else begin
      r_phase <= r_phase + R_LOG2'(1);

      if (w_strobe && !in_valid) begin
        r_underflow <= 1'b1;
      end

      for (int c = 0; c < 2; c++) begin
        // Sample load and comb delay update share the strobe edge.
        if (w_strobe) begin
          r_samp[c] <= in_valid ? w_in[c] : '0;
          for (int k = 0; k < N_STAGES; k++) begin
            r_dly[c][k] <= w_cmb[c][k];
          end
        end

        // Zero-stuffing: comb output only in the cycle after the strobe.
        r_stuff[c] <= (r_phase == '0) ? w_cmb[c][N_STAGES] : '0;

        r_int[c][0] <= r_int[c][0] + r_stuff[c];
        for (int k = 1; k < N_STAGES; k++) begin
          r_int[c][k] <= r_int[c][k] + r_int[c][k-1];
        end

`ifdef QDUC_ROUND_SAT_EN
        r_pipe[c] <= w_norm[c];
        r_out[c]  <= r_pipe[c];
`else
        r_out[c]  <= w_norm[c];
`endif
      end

      // Valid shift chain: set by the first strobe, output goes high LAT edges later.
      r_vsr       <= {r_vsr[LAT-2:0], r_vsr[0] | w_strobe};
      r_out_valid <= r_vsr[LAT-1];
    end
  end

  assign out_i     = r_out[0];
  assign out_q     = r_out[1];
  assign out_valid = r_out_valid;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_qduc_interp.sv
// tb_qduc_interp: randomized self-checking bench for qduc_interp.
// Reference model: list of accepted samples convolved with the N-fold box
// impulse response of a zero-stuffed CIC interpolator, then normalised.
module tb_qduc_interp;

  localparam int ISZ  = 16;
  localparam int OSZ  = 14;
  localparam int NST  = 3;
  localparam int RL2  = 8;
  localparam int R    = 1 << RL2;
  localparam int S    = (NST - 1) * RL2 + (ISZ - OSZ);
  localparam int HLEN = NST * (R - 1) + 1;
`ifdef QDUC_ROUND_SAT_EN
  localparam int LAT  = NST + 3;
`else
  localparam int LAT  = NST + 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [ISZ-1:0] in_i;
  logic [ISZ-1:0] in_q;
  logic           in_valid;
  logic           in_ready;
  logic [OSZ-1:0] out_i;
  logic [OSZ-1:0] out_q;
  logic           out_valid;
  logic           underflow;

  always #5 clk = ~clk;

  qduc_interp #(
    .ISZ(ISZ), .OSZ(OSZ), .N_STAGES(NST), .R_LOG2(RL2)
  ) dut (
    .clk(clk), .reset(rst), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
    .in_ready(in_ready), .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
    .underflow(underflow)
  );

  int     checks   = 0;
  int     failures = 0;
  longint h   [HLEN];
  longint tmp [HLEN];
  int     mphase = 0;
  bit     munder = 1'b0;
  int     mfirst = -1;
  int     ecount = 0;
  int     s_edge [$];
  longint s_i    [$];
  longint s_q    [$];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got=%0d expected=%0d", tag, ecount, got, exp);
    end
  endtask

  function automatic longint norm(input longint y);
    longint v;
`ifdef QDUC_ROUND_SAT_EN
    v = (y + (64'sd1 <<< (S - 1))) >>> S;
    if (v > (64'sd1 <<< (OSZ - 1)) - 1) v = (64'sd1 <<< (OSZ - 1)) - 1;
    if (v < -(64'sd1 <<< (OSZ - 1)))    v = -(64'sd1 <<< (OSZ - 1));
`else
    v = y >>> S;
    v = v & ((64'sd1 <<< OSZ) - 1);
    if (v >= (64'sd1 <<< (OSZ - 1))) v = v - (64'sd1 <<< OSZ);
`endif
    return v;
  endfunction

  // Ideal interpolator output after edge e for channel ch.
  function automatic longint model_y(input int e, input int ch);
    longint acc = 0;
    for (int j = 0; j < s_edge.size(); j++) begin
      int m = e - s_edge[j] - LAT;
      if (m >= 0 && m < HLEN) acc += (ch == 0 ? s_i[j] : s_q[j]) * h[m];
    end
    return acc;
  endfunction

  // One clock: check in_ready, advance the model, then check outputs after the edge.
  task automatic tick();
    bit exp_rdy;
    exp_rdy = !rst && (mphase == R - 1);
    check("in_ready", longint'(in_ready), longint'(exp_rdy));
    if (rst) begin
      mphase = 0; munder = 1'b0; mfirst = -1;
      s_edge.delete(); s_i.delete(); s_q.delete();
    end else begin
      if (mphase == R - 1) begin
        if (mfirst < 0) mfirst = ecount + 1;
        if (in_valid) begin
          s_edge.push_back(ecount + 1);
          s_i.push_back(longint'($signed(in_i)));
          s_q.push_back(longint'($signed(in_q)));
        end else begin
          munder = 1'b1;
        end
      end
      mphase = (mphase + 1) % R;
    end
    @(posedge clk);
    ecount++;
    @(negedge clk);
    while (s_edge.size() > 0 && ecount - s_edge[0] - LAT >= HLEN) begin
      void'(s_edge.pop_front()); void'(s_i.pop_front()); void'(s_q.pop_front());
    end
    check("out_i", longint'($signed(out_i)), norm(model_y(ecount, 0)));
    check("out_q", longint'($signed(out_q)), norm(model_y(ecount, 1)));
    check("out_valid", longint'(out_valid), longint'(mfirst >= 0 && ecount >= mfirst + LAT));
    check("underflow", longint'(underflow), longint'(munder));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic to_phase(input int p);
    for (int k = 0; k < 2 * R; k++) begin
      if (mphase == p) break;
      tick();
    end
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      in_i     = ISZ'($urandom);
      in_q     = ISZ'($urandom);
      in_valid = ($urandom_range(0, 9) != 0);
      tick();
    end
  endtask

  initial begin
    int n;
    longint run_s;

    // Impulse response of N cascaded length-R boxes.
    for (int m = 0; m < HLEN; m++) h[m] = (m < R) ? 64'sd1 : 64'sd0;
    for (int st = 1; st < NST; st++) begin
      run_s = 0;
      for (int m = 0; m < HLEN; m++) begin
        run_s += h[m];
        if (m >= R) run_s -= h[m - R];
        tmp[m] = run_s;
      end
      for (int m = 0; m < HLEN; m++) h[m] = tmp[m];
    end

    // Reset with a transfer presented.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_i = ISZ'(1000); in_q = ISZ'(1000);
    run(3);
    check("rst_out_i", longint'($signed(out_i)), 0);
    check("rst_out_valid", longint'(out_valid), 0);

    // First in_ready after release.
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 2 * R; k++) begin
      n++;
      if (in_ready === 1'b1) break;
      tick();
    end
    check("first_ready", n, R);

    // DC gain.
    in_i = ISZ'(4000); in_q = ISZ'(-4000);
    run(8 * R);
    check("dc_i", longint'($signed(out_i)), norm(64'sd4000 << ((NST - 1) * RL2)));
    check("dc_q", longint'($signed(out_q)), norm(-64'sd4000 << ((NST - 1) * RL2)));

    // Underflow: one strobe without data, sticky afterwards.
    in_valid = 1'b0;
    to_phase(R - 1);
    tick();
    in_valid = 1'b1;
    check("underflow_set", longint'(underflow), 1);
    run(2 * R);
    check("underflow_sticky", longint'(underflow), 1);

    // Full scale.
`ifdef QDUC_ROUND_SAT_EN
    in_i = ISZ'(32767);
    run(8 * R);
    check("fullscale_i", longint'($signed(out_i)), 8191);
`else
    in_i = ISZ'(-32768);
    run(8 * R);
    check("fullscale_i", longint'($signed(out_i)), -8192);
`endif

    // Impulse latency and tail.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_i = ISZ'(-32768); in_q = '0;
    to_phase(R - 1);
    tick();
    in_i = '0;
    for (int k = 1; k < LAT; k++) begin
      tick();
      check("lat_pre", longint'($signed(out_i)), 0);
    end
    tick();
    check("lat_first", longint'($signed(out_i)), norm(-64'sd32768));
    run(800);
    check("impulse_tail", longint'($signed(out_i)), 0);

    // Random stream, reset mid-stream, random restart.
    run_random(12 * R);
    to_phase(100);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    check("mid_rst_i", longint'($signed(out_i)), 0);
    check("mid_rst_q", longint'($signed(out_q)), 0);
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_under", longint'(underflow), 0);
    rst = 1'b0;
    run_random(10 * R);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
